// File: rtl/ps2_piano_keys.sv
// PS/2 receiver mapping A,S,D,F,G,H,J make/break codes onto a held-key bitmap.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with even parity.
module ps2_piano_keys #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [6:0] keyNum,
  output logic       newPress,
  output logic       frameErr,
  output logic [1:0] rx_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} rx_state_t;

  rx_state_t   state, state_next;
  logic        clk_s1, clk_s2, clk_s3;
  logic        dat_s1, dat_s2;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        stop_bit;
  logic [15:0] to_cnt;
  logic        brk, ext;
  logic        fall, timeout_hit, frame_ok;
  logic [6:0]  key_mask, key_next;
  logic        press_next, err_next, brk_next, ext_next;
`ifdef PS2_PARITY_CHECK_EN
  logic        parity_bit;
`endif

  assign rx_state    = state;
  assign fall        = clk_s3 & ~clk_s2;
  assign timeout_hit = (state == SHIFT) && !fall && (to_cnt == TIMEOUT - 16'd1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall && !dat_s2) state_next = SHIFT;
      SHIFT:   if (timeout_hit) state_next = IDLE;
               else if (fall && bit_cnt == 4'd9) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_mask = 7'b0;
    case (shift_reg)
      8'h1C: key_mask = 7'b0000001;
      8'h1B: key_mask = 7'b0000010;
      8'h23: key_mask = 7'b0000100;
      8'h2B: key_mask = 7'b0001000;
      8'h34: key_mask = 7'b0010000;
      8'h33: key_mask = 7'b0100000;
      8'h3B: key_mask = 7'b1000000;
      default: key_mask = 7'b0;
    endcase
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = stop_bit & (^{parity_bit, shift_reg});
`else
  assign frame_ok = stop_bit;
`endif

  // Byte interpretation happens in CHECK; results register on the edge leaving it.
  always_comb begin
    key_next   = keyNum;
    press_next = 1'b0;
    err_next   = 1'b0;
    brk_next   = brk;
    ext_next   = ext;
    if (state == CHECK) begin
      if (!frame_ok) begin
        err_next = 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_next = 1'b1;
      end else if (shift_reg == 8'hE0) begin
        ext_next = 1'b1;
      end else begin
        if (!ext && key_mask != 7'b0)
          key_next = brk ? (keyNum & ~key_mask) : (keyNum | key_mask);
        press_next = (key_next != keyNum);
        brk_next   = 1'b0;
        ext_next   = 1'b0;
      end
    end
    if (timeout_hit) err_next = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_s3 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'd0;
      stop_bit  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
      to_cnt    <= 16'd0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      keyNum    <= 7'd0;
      newPress  <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      clk_s1 <= PS2_CLK; clk_s2 <= clk_s1; clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT; dat_s2 <= dat_s1;
      state  <= state_next;
      to_cnt <= (fall || state != SHIFT) ? 16'd0 : to_cnt + 16'd1;
      if (state == IDLE) begin
        bit_cnt <= 4'd0;
        if (fall && !dat_s2) shift_reg <= 8'd0;
      end else if (state == SHIFT && fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd8) shift_reg <= {dat_s2, shift_reg[7:1]};
`ifdef PS2_PARITY_CHECK_EN
        if (bit_cnt == 4'd8) parity_bit <= dat_s2;
`endif
        if (bit_cnt == 4'd9) stop_bit <= dat_s2;
      end
      brk      <= brk_next;
      ext      <= ext_next;
      keyNum   <= key_next;
      newPress <= press_next;
      frameErr <= err_next;
    end
  end

endmodule

// File: tb/tb_ps2_piano_keys.sv
// Randomized scoreboard bench for ps2_piano_keys against a key-table reference model.
module tb_ps2_piano_keys;
  localparam logic [15:0] TMO  = 16'd200;
  localparam int          HALF = 10;
  localparam int          GAP  = 30;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [6:0] keyNum;
  logic       newPress, frameErr;
  logic [1:0] rx_state;

  ps2_piano_keys #(.TIMEOUT(TMO)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .keyNum(keyNum), .newPress(newPress), .frameErr(frameErr), .rx_state(rx_state)
  );

  // Clock/reset
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each entry is {keyNum, newPress, frameErr} at a pulse
  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: held keys, prefix flags
  logic [7:0] key_tab[7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};
  logic [6:0] held = 7'd0;
  bit m_brk = 0;
  bit m_ext = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [6:0] nk;
    if (!ok) begin
      exp_q.push_back({held, 1'b0, 1'b1});
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      nk = held;
      for (int i = 0; i < 7; i++)
        if (!m_ext && key_tab[i] == b) nk[i] = !m_brk;
      if (nk != held) exp_q.push_back({nk, 1'b1, 1'b0});
      held  = nk;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  // Monitor
  always @(negedge CLOCK_50) begin
    if (Resetn && (newPress || frameErr)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got key=%b np=%b fe=%b expected no pulse", keyNum, newPress, frameErr);
      end else begin
        check("pulse", {keyNum, newPress, frameErr}, exp_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    bit ok;
    ok = stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && !bad_par;
`endif
    model_byte(d, ok);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ bad_par);
    ps2_bit(stop);
    PS2_DAT = 1'b1;
    wait_cyc(GAP);
    check("key_after_frame", keyNum, held);
  endtask

  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
    PS2_DAT = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    wait_cyc(5);
    check("rst_key", keyNum, 7'd0);
    check("rst_np", newPress, 1'b0);
    check("rst_fe", frameErr, 1'b0);
    check("rst_state", rx_state, 2'd0);
    Resetn = 1'b1;
    wait_cyc(5);

    send_frame(8'h1C, 0, 1);
    check("first_make", keyNum, 7'b0000001);
    send_frame(8'h23, 0, 1);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1C, 0, 1);
    check("break_a", keyNum, 7'b0000100);
    send_frame(8'h1C, 0, 1);
    send_frame(8'h1C, 0, 1);
    send_frame(8'hE0, 0, 1);
    send_frame(8'h1C, 0, 1);
    send_frame(8'h2A, 0, 1);
    send_frame(8'h1B, 0, 0);
    send_frame(8'h1B, 1, 1);

    send_partial(4);
    model_byte(8'h00, 0);
    wait_cyc(int'(TMO) + 20);
    check("timeout_idle", rx_state, 2'd0);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1B, 0, 1);
    send_frame(8'h1B, 0, 1);
    check("after_timeout", keyNum[1], 1'b1);

    send_partial(3);
    Resetn = 1'b0;
    wait_cyc(3);
    held = 7'd0; m_brk = 0; m_ext = 0;
    check("midrst_key", keyNum, 7'd0);
    check("midrst_np", newPress, 1'b0);
    check("midrst_fe", frameErr, 1'b0);
    Resetn = 1'b1;
    wait_cyc(GAP);
    check("midrst_state", rx_state, 2'd0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       b = key_tab[$urandom_range(0, 6)];
      else if (r == 6) b = 8'hF0;
      else if (r == 7) b = 8'hE0;
      else             b = 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 14) == 0, $urandom_range(0, 14) != 0);
    end

    wait_cyc(50);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
